// File: rtl/def_ss_merge_if.sv
// def_ss_merge_if: tagged valid/ready output stream of the channel merger
interface def_ss_merge_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic                  chan;
    logic [DATA_WIDTH-1:0] data;
    modport master(output valid, chan, data, input ready);
    modport slave(input valid, chan, data, output ready);
endinterface

// File: rtl/def_ss_merge.sv
// def_ss_merge: change-detect two channels, round-robin merge into a tagged FIFO stream
module def_ss_merge #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       i_data_0,
    input  logic [DATA_WIDTH-1:0]       i_data_1,
    def_ss_merge_if.master              stream,
    output logic [DROP_CNT_WIDTH-1:0]   o_drop_cnt_0,
    output logic [DROP_CNT_WIDTH-1:0]   o_drop_cnt_1,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0]     din    [2];
    logic [DATA_WIDTH-1:0]     last   [2];
    logic [DATA_WIDTH-1:0]     pend_d [2];
    logic [DROP_CNT_WIDTH-1:0] drop   [2];
    logic [DATA_WIDTH:0]       mem    [FIFO_DEPTH];
    logic [1:0]                pend_v, chg, gnt;
    logic                      rr, full, gnt_v, gnt_ch, rd;
    logic [AW-1:0]             wp, rp;
    logic [LW-1:0]             level;

    assign din[0]       = i_data_0;
    assign din[1]       = i_data_1;
    assign o_drop_cnt_0 = drop[0];
    assign o_drop_cnt_1 = drop[1];
    assign o_fifo_level = level;
    assign stream.valid = level != '0;
    assign {stream.chan, stream.data} = stream.valid ? mem[rp] : '0;

    // change detection, round-robin grant (no credit for a same-cycle read) and sink handshake
    always_comb begin
        chg[0] = din[0] != last[0];
        chg[1] = din[1] != last[1];
        full   = level == LW'(FIFO_DEPTH);
        gnt_v  = !full && |pend_v;
        gnt_ch = &pend_v ? rr : pend_v[1];
        gnt    = gnt_v ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
        rd     = stream.valid && stream.ready;
    end

    // per-channel history, pending slot and saturating drop count; a granted slot may reload
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                last[k]   <= '0;
                pend_v[k] <= 1'b0;
                drop[k]   <= '0;
            end else begin
                last[k] <= din[k];
                if (chg[k] && pend_v[k] && !gnt[k] && drop[k] != '1)
                    drop[k] <= drop[k] + 1'b1;
                if (chg[k]) begin
                    pend_v[k] <= 1'b1;
                    pend_d[k] <= din[k];
                end else if (gnt[k]) begin
                    pend_v[k] <= 1'b0;
                end
            end
        end
    end

    // arbiter pointer and FIFO pointers/level
    always_ff @(posedge clk) begin
        if (rst) begin
            rr    <= 1'b0;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (gnt_v)
                rr <= ~gnt_ch;
            wp    <= wp + AW'(gnt_v);
            rp    <= rp + AW'(rd);
            level <= level + LW'(gnt_v) - LW'(rd);
        end
    end

    // FIFO storage is deliberately not reset; the output mux hides it while empty
    always_ff @(posedge clk) begin
        if (gnt_v)
            mem[wp] <= {gnt_ch, pend_d[gnt_ch]};
    end
endmodule

// File: tb/tb_def_ss_merge.sv
// tb_def_ss_merge: vector table plus corner sequences, scoreboard on the output stream
module tb_def_ss_merge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = '0, d1 = '0;
    logic [7:0] drop0, drop1;
    logic [2:0] level;
    int         errors = 0, checks = 0;
    logic [8:0] q[$];

    def_ss_merge_if #(.DATA_WIDTH(8)) bus();

    def_ss_merge #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DROP_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i_data_0(d0), .i_data_1(d1), .stream(bus),
        .o_drop_cnt_0(drop0), .o_drop_cnt_1(drop1), .o_fifo_level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // sampled at negedge: a visible valid&&ready completes at the following posedge
    always @(negedge clk) begin
        if (!rst && bus.valid && bus.ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected: got %0h want nothing", {bus.chan, bus.data});
            end else begin
                chk("stream", {bus.chan, bus.data}, q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        d0 = '0;
        d1 = '0;
        bus.ready = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", bus.valid, 0);
        chk("rst_head", {bus.chan, bus.data}, 0);
        chk("rst_level", level, 0);
        chk("rst_drop0", drop0, 0);
        chk("rst_drop1", drop1, 0);
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (4) @(negedge clk);
        for (int i = 0; i < n && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
        @(negedge clk);
        chk("level_empty", level, 0);
    endtask

    typedef struct {
        logic [7:0] d0, d1;
        int         n;
        logic [8:0] e0, e1;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{8'h11, 8'h22, 2, 9'h011, 9'h122};
        tbl[1] = '{8'h5A, 8'h22, 1, 9'h05A, 9'h000};
        tbl[2] = '{8'h33, 8'h44, 2, 9'h144, 9'h033};
        tbl[3] = '{8'h33, 8'h55, 1, 9'h155, 9'h000};
        tbl[4] = '{8'h66, 8'h77, 2, 9'h066, 9'h177};
        tbl[5] = '{8'h66, 8'h77, 0, 9'h000, 9'h000};
        tbl[6] = '{8'h00, 8'h00, 2, 9'h000, 9'h100};
        bus.ready = 1'b0;

        // single change: latency 2, one-cycle pulse
        do_reset();
        bus.ready = 1'b1;
        @(negedge clk);
        d0 = 8'h5A;
        q.push_back(9'h05A);
        @(negedge clk);
        chk("lat_e0_valid", bus.valid, 0);
        @(negedge clk);
        chk("lat_e1_valid", bus.valid, 1);
        chk("lat_e1_head", {bus.chan, bus.data}, 9'h05A);
        @(negedge clk);
        chk("lat_e2_valid", bus.valid, 0);
        chk("lat_drop0", drop0, 0);

        // vector table: rr alternation and change detection
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d0 = tbl[i].d0;
            d1 = tbl[i].d1;
            if (tbl[i].n > 0) q.push_back(tbl[i].e0);
            if (tbl[i].n > 1) q.push_back(tbl[i].e1);
            drain(20);
        end
        chk("tbl_drop0", drop0, 0);
        chk("tbl_drop1", drop1, 0);

        // back-pressure: fill FIFO, overwrite pending 5 with 6
        do_reset();
        for (int v = 1; v <= 6; v++) begin
            d0 = 8'(v);
            @(negedge clk);
        end
        chk("bp_level", level, 4);
        chk("bp_drop0", drop0, 1);
        chk("bp_head", {bus.chan, bus.data}, 9'h001);
        repeat (3) @(negedge clk);
        chk("bp_head_hold", {bus.chan, bus.data}, 9'h001);
        chk("bp_level_hold", level, 4);
        q.push_back(9'h001);
        q.push_back(9'h002);
        q.push_back(9'h003);
        q.push_back(9'h004);
        q.push_back(9'h006);
        bus.ready = 1'b1;
        drain(30);
        chk("bp_drop0_after", drop0, 1);

        // saturation of channel-1 drop counter
        do_reset();
        for (int i = 0; i < 300; i++) begin
            d1 = (i % 2 == 0) ? 8'h01 : 8'h00;
            @(negedge clk);
        end
        chk("sat_drop1", drop1, 255);
        for (int i = 0; i < 6; i++) begin
            d1 = (i % 2 == 0) ? 8'h01 : 8'h00;
            @(negedge clk);
        end
        chk("sat_drop1_hold", drop1, 255);
        chk("sat_drop0", drop0, 0);
        chk("sat_level", level, 4);

        // grant and change in the same cycle: reload without drop
        do_reset();
        bus.ready = 1'b1;
        d0 = 8'hA0;
        q.push_back(9'h0A0);
        @(negedge clk);
        d0 = 8'hA1;
        q.push_back(9'h0A1);
        @(negedge clk);
        chk("gc_drop0", drop0, 0);
        drain(20);
        chk("gc_drop0_after", drop0, 0);

        // reset mid-operation with level 3 and both slots pending
        do_reset();
        d0 = 8'h01;
        @(negedge clk);
        d0 = 8'h02;
        @(negedge clk);
        d0 = 8'h03;
        @(negedge clk);
        d0 = 8'h04;
        d1 = 8'h09;
        @(negedge clk);
        chk("mid_level", level, 3);
        rst = 1'b1;
        bus.ready = 1'b1;
        d0 = '0;
        d1 = '0;
        @(negedge clk);
        chk("mid_valid", bus.valid, 0);
        chk("mid_level_rst", level, 0);
        chk("mid_drop0", drop0, 0);
        chk("mid_drop1", drop1, 0);
        q.delete();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_idle_valid", bus.valid, 0);
        end
        chk("mid_idle_level", level, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
